// File: rtl/seq_rec_pkg.sv
// seq_rec_pkg: shared FSM state type and default sizes for the sequence recognizer
package seq_rec_pkg;
   typedef enum logic [1:0] {UNLOADED, FILL, RUN} state_t;
   localparam int DEF_MAX_LEN = 8;
   localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/seq_recognizer_param_sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);
   // clear wins over increment; increment stops at the maximum value
   always_ff @(posedge clock or posedge reset)
      if (reset) count <= '0;
      else if (clr) count <= '0;
      else if (inc && count != '1) count <= count + W'(1);
endmodule

// File: rtl/seq_recognizer_param.sv
// seq_recognizer_param: serial pattern recognizer with loadable pattern/length and overlap control
module seq_recognizer_param
   import seq_rec_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               x,
   input  logic               x_valid,
   input  logic               pat_load,
   input  logic [MAX_LEN-1:0] pat_data,
   input  logic [LEN_W-1:0]   pat_len,
   input  logic               overlap,
   input  logic               count_clr,
   output logic               z,
   output logic [CNT_W-1:0]   match_count,
   output logic               armed,
   output logic               cfg_err
);
   state_t             state;
   logic [MAX_LEN-1:0] hist, pat, nxt_hist, mask;
   logic [LEN_W-1:0]   len, fill, nxt_fill;
   logic               load_ok, accept, match, restart;

   assign load_ok  = pat_len >= LEN_W'(2) && pat_len <= LEN_W'(MAX_LEN);
   assign accept   = x_valid && !pat_load && state != UNLOADED;
   assign nxt_hist = (hist << 1) | {{(MAX_LEN-1){1'b0}}, x};
   assign nxt_fill = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
   // all-ones in the low len bits; a shift by MAX_LEN leaves the whole mask set
   assign mask     = ~({MAX_LEN{1'b1}} << len);
   assign match    = accept && nxt_fill >= len && ((nxt_hist ^ pat) & mask) == '0;
   assign restart  = match && !overlap;

   // control FSM, shift history, fill count and registered flags
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state   <= UNLOADED;
         hist    <= '0;
         fill    <= '0;
         pat     <= '0;
         len     <= '0;
         z       <= 1'b0;
         armed   <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         z <= match;
         if (pat_load) begin
            hist    <= '0;
            fill    <= '0;
            armed   <= load_ok;
            cfg_err <= !load_ok;
            state   <= load_ok ? FILL : UNLOADED;
            if (load_ok) begin
               pat <= pat_data;
               len <= pat_len;
            end
         end else if (accept) begin
            hist  <= nxt_hist;
            fill  <= restart ? '0 : nxt_fill;
            state <= (restart || nxt_fill < len) ? FILL : RUN;
         end
      end

   sat_counter #(.W(CNT_W)) u_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (count_clr || pat_load),
      .inc   (match),
      .count (match_count)
   );
endmodule

// File: doc/seq_recognizer_param.md
SEQ_RECOGNIZER_PARAM -- requirements
Module: seq_recognizer_param

Interface
REQ-001 Parameter MAX_LEN, default 8: the longest pattern supported, in bits (range 2..16).
REQ-002 Parameter CNT_W, default 8: width of the match counter.
REQ-003 Parameter LEN_W, default $clog2(MAX_LEN+1): width of the length field.
REQ-004 Port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port x, input, 1: serial data bit.
REQ-007 Port x_valid, input, 1: x is sampled only when x_valid=1.
REQ-008 Port pat_load, input, 1: one-cycle strobe that loads a new pattern.
REQ-009 Port pat_data, input, MAX_LEN: pattern bits; bit pat_len-1 is received first and bit 0 is received last.
REQ-010 Port pat_len, input, LEN_W: pattern length in bits.
REQ-011 Port overlap, input, 1: 1 selects overlapping detection, 0 selects non-overlapping detection; it is sampled on every accepted bit.
REQ-012 Port count_clr, input, 1: synchronous clear of the match counter.
REQ-013 Port z, output, 1: registered match pulse.
REQ-014 Port match_count, output, CNT_W: number of matches detected.
REQ-015 Port armed, output, 1: a valid pattern is loaded.
REQ-016 Port cfg_err, output, 1: the last load was rejected.

Function
REQ-017 FSM states are UNLOADED, FILL and RUN.
- UNLOADED -> FILL on a valid load.
- FILL -> RUN when the fill count reaches pat_len.
- RUN -> FILL after a non-overlap match.
- Any state -> FILL on a valid load.
- Any state -> UNLOADED on a rejected load.
REQ-018 A load is valid iff 2 <= pat_len <= MAX_LEN.
- A valid load latches pattern and length, clears the history and fill count, sets armed=1 and cfg_err=0.
REQ-019 A rejected load sets armed=0 and cfg_err=1, and clears the history and fill count.
REQ-020 pat_load has priority over x_valid in the same cycle; that cycle's x is discarded.
REQ-021 An accepted bit (x_valid=1, armed=1) shifts into the history at bit 0 and increments the fill count, saturating at MAX_LEN.
REQ-022 A match occurs on an accepted bit when:
- the post-shift fill count is >= the latched length, and
- the low latched-length bits of the history equal the same bits of the latched pattern.
REQ-023 z=1 for exactly one cycle, the cycle after the clock edge that accepted the completing bit; otherwise z=0.
REQ-024 With overlap=0, a match clears the fill count, so the next match needs a full new pattern length of bits.
REQ-025 With overlap=1, the history is retained after a match.
REQ-026 match_count increments by 1 per match and saturates at 2^CNT_W-1 without wrapping.
REQ-027 count_clr=1 sets match_count to 0.
- count_clr takes priority over a same-cycle increment.
- z still pulses for that match.
REQ-028 While x_valid=0, all state holds and z=0.
REQ-029 In UNLOADED, x is ignored and no match is possible.
REQ-030 A load clears match_count to 0.

Reset
REQ-031 Reset asserted forces, asynchronously:
- state UNLOADED;
- history, fill count and stored pattern to 0;
- z=0, match_count=0, armed=0, cfg_err=0.
REQ-032 Reset asserted mid-sequence discards any partial match; after release, nothing matches until a new valid load.

Structure
REQ-033 A shared package seq_rec_pkg holds:
- the FSM state enum (UNLOADED, FILL, RUN);
- the default MAX_LEN and CNT_W constants.
REQ-034 A single sub-module sat_counter (CNT_W-wide: clear, increment, saturate) implements match_count; all other logic stays in seq_recognizer_param.

Verification
REQ-035 Load pattern 1011 (pat_len=4, pat_data=4'b1011), overlap=1, stream 1,0,1,1,0,1,1 -> z pulses after bit 4 and bit 7; match_count=2.
REQ-036 Same load and stream with overlap=0 -> z pulses after bit 4 only; match_count=1.
REQ-037 Load with pat_len=1, and separately with pat_len=MAX_LEN+1 -> cfg_err=1, armed=0, and a matching stream gives z=0 and match_count=0.
REQ-038 Pattern 11 (pat_len=2), overlap=1, CNT_W=2, stream of 6 ones -> z on bits 2..6; match_count saturates at 3; count_clr then gives 0.
REQ-039 Reset asserted after 3 of 4 pattern bits, asynchronously between clock edges -> outputs clear immediately; after reload, the 4th bit alone gives no match.
REQ-040 pat_load and x_valid asserted in the same cycle -> the load is taken, x is discarded, and the fill count is 0 next cycle.
